alu_operand_stage: RTL and testbench

- Decode-to-execute pipeline register that sits directly upstream of the ALU.
- Captures one decoded instruction and selects both ALU operands: rs1 or PC for operand A, rs2 or immediate for operand B.
- Drives alumux1_out, alumux2_out and aluop straight into the ALU inputs.
- Single-entry buffer with valid/ready handshake, flush, and writeback snooping, so operands held during a stall stay current.

---
 rtl/alu_operand_stage.sv | 128 ++++++++++++
 tb/tb_alu_operand_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// -----------------
// Decode-to-execute pipeline register that sits directly in front of the ALU.
// It holds one decoded instruction and presents both ALU operands, the ALU
// operation and the destination register. Operand A is rs1 or the PC, and
// operand B is rs2 or the immediate. The handshake is valid/ready with a
// single entry and no skid buffer, so in_ready is combinational.
//
// Build option: define WB_FORWARD_EN to enable writeback forwarding. With it
// defined, a writeback that targets a source register replaces the register
// file data at capture time. It also updates a register operand in place while
// the entry is stalled. Without it, the wb_* ports are ignored, and decode must
// stall on hazards.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   in_valid / in_ready           upstream handshake
//   in_aluop, in_rd_addr          decoded operation and destination register
//   in_rs1_addr/data, in_rs2_addr/data   source register addresses and RF data
//   in_pc, in_imm                 instruction PC and sign-extended immediate
//   in_sel_a, in_sel_b            operand selects (0 = register, 1 = PC/imm)
//   flush                         drop held and incoming instruction
//   wb_valid, wb_rd, wb_data      writeback snoop port
//   out_valid / out_ready         downstream handshake
//   alumux1_out, alumux2_out      registered ALU operands A and B
//   aluop, out_rd_addr            registered operation and destination
module alu_operand_stage #(
  parameter int XLEN     = 32,
  parameter int OP_WIDTH = 4,
  parameter int REG_AW   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_WIDTH-1:0] in_aluop,
  input  logic [REG_AW-1:0]   in_rs1_addr,
  input  logic [REG_AW-1:0]   in_rs2_addr,
  input  logic [XLEN-1:0]     in_rs1_data,
  input  logic [XLEN-1:0]     in_rs2_data,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [XLEN-1:0]     in_imm,
  input  logic                in_sel_a,
  input  logic                in_sel_b,
  input  logic [REG_AW-1:0]   in_rd_addr,
  input  logic                flush,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     alumux1_out,
  output logic [XLEN-1:0]     alumux2_out,
  output logic [OP_WIDTH-1:0] aluop,
  output logic [REG_AW-1:0]   out_rd_addr
);

`ifdef WB_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // Held copies of the source addresses and selects. The snoop logic uses them
  // to decide whether a stalled register operand must follow a writeback.
  logic [REG_AW-1:0] rs1_q, rs2_q;
  logic              sel_a_q, sel_b_q;

  logic              capture;
  logic              consume;
  logic              wb_hit_in1, wb_hit_in2;
  logic              wb_hit_q1, wb_hit_q2;
  logic [XLEN-1:0]   fwd1, fwd2;

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign consume  = out_valid && out_ready;

  // x0 is hardwired to zero, so a writeback to it is never forwarded.
  assign wb_hit_in1 = FWD_EN && wb_valid && (wb_rd == in_rs1_addr) && (in_rs1_addr != '0);
  assign wb_hit_in2 = FWD_EN && wb_valid && (wb_rd == in_rs2_addr) && (in_rs2_addr != '0);
  assign fwd1       = wb_hit_in1 ? wb_data : in_rs1_data;
  assign fwd2       = wb_hit_in2 ? wb_data : in_rs2_data;

  // A held operand follows a writeback only if it came from a register.
  // PC and immediate operands are never overwritten.
  assign wb_hit_q1 = FWD_EN && wb_valid && (wb_rd == rs1_q) && (rs1_q != '0) && !sel_a_q;
  assign wb_hit_q2 = FWD_EN && wb_valid && (wb_rd == rs2_q) && (rs2_q != '0) && !sel_b_q;

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alumux1_out <= '0;
      alumux2_out <= '0;
      aluop       <= '0;
      out_rd_addr <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      sel_a_q     <= 1'b0;
      sel_b_q     <= 1'b0;
    end else if (flush) begin
      // Flush wins over capture, consume and snoop. The data registers keep
      // whatever they hold, because out_valid masks them.
      out_valid <= 1'b0;
    end else if (capture) begin
      // A capture covers both the empty case and the back-to-back case
      // (consume and refill in the same cycle).
      out_valid   <= 1'b1;
      alumux1_out <= in_sel_a ? in_pc  : fwd1;
      alumux2_out <= in_sel_b ? in_imm : fwd2;
      aluop       <= in_aluop;
      out_rd_addr <= in_rd_addr;
      rs1_q       <= in_rs1_addr;
      rs2_q       <= in_rs2_addr;
      sel_a_q     <= in_sel_a;
      sel_b_q     <= in_sel_b;
    end else if (consume) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // Stalled: keep operands current with writebacks that land meanwhile.
      if (wb_hit_q1) alumux1_out <= wb_data;
      if (wb_hit_q2) alumux2_out <= wb_data;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage. A transaction-level model holds
// at most one pending instruction with its resolved operands. It applies the
// handshake, flush, forwarding and snoop rules from plain conditions and is
// compared with the DUT after every clock edge. Directed cases pin the model
// to hand-computed literals, and a randomized phase follows.
module tb_alu_operand_stage;
  localparam int XLEN = 32, OPW = 4, AW = 5;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [OPW-1:0]  in_aluop;
  logic [AW-1:0]   in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
  logic            in_sel_a, in_sel_b, flush;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] alumux1_out, alumux2_out;
  logic [OPW-1:0]  aluop;
  logic [AW-1:0]   out_rd_addr;

  alu_operand_stage #(.XLEN(XLEN), .OP_WIDTH(OPW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_pc(in_pc), .in_imm(in_imm), .in_sel_a(in_sel_a), .in_sel_b(in_sel_b),
    .in_rd_addr(in_rd_addr), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alumux1_out(alumux1_out), .alumux2_out(alumux2_out),
    .aluop(aluop), .out_rd_addr(out_rd_addr)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Model of the pending instruction: what the ALU should be seeing.
  typedef struct {
    bit              valid;
    logic [XLEN-1:0] a, b;
    logic [OPW-1:0]  op;
    logic [AW-1:0]   rd, rs1, rs2;
    bit              a_is_reg, b_is_reg;
  } entry_t;
  entry_t m;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register read value as seen by an instruction: the newest writeback wins,
  // except for x0.
  function automatic logic [XLEN-1:0] reg_value(input logic [AW-1:0] a, input logic [XLEN-1:0] rf);
    if (FWD && wb_valid && wb_rd == a && a != 0) return wb_data;
    return rf;
  endfunction

  task automatic model_edge();
    bit accept;
    accept = in_valid && (!m.valid || out_ready);
    if (flush) m.valid = 0;
    else if (accept) begin
      m.valid    = 1;
      m.a        = in_sel_a ? in_pc  : reg_value(in_rs1_addr, in_rs1_data);
      m.b        = in_sel_b ? in_imm : reg_value(in_rs2_addr, in_rs2_data);
      m.op       = in_aluop;
      m.rd       = in_rd_addr;
      m.rs1      = in_rs1_addr;
      m.rs2      = in_rs2_addr;
      m.a_is_reg = !in_sel_a;
      m.b_is_reg = !in_sel_b;
    end else if (m.valid && out_ready) m.valid = 0;
    else if (m.valid) begin
      if (m.a_is_reg) m.a = reg_value(m.rs1, m.a);
      if (m.b_is_reg) m.b = reg_value(m.rs2, m.b);
    end
  endtask

  // One cycle: inputs are already driven (we are just after a negedge).
  task automatic step();
    #1 check("in_ready", in_ready, !m.valid || out_ready);
    @(posedge clk);
    model_edge();
    #1;
    check("out_valid", out_valid, m.valid);
    if (m.valid) begin
      check("alumux1_out", alumux1_out, m.a);
      check("alumux2_out", alumux2_out, m.b);
      check("aluop", aluop, m.op);
      check("out_rd_addr", out_rd_addr, m.rd);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; in_aluop = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_pc = 0; in_imm = 0;
    in_sel_a = 0; in_sel_b = 0; flush = 0; wb_valid = 0; wb_rd = 0; wb_data = 0;
    out_ready = 1;
  endtask

  task automatic issue(input logic [OPW-1:0] op, input logic [AW-1:0] r1, input logic [XLEN-1:0] d1,
                       input logic [AW-1:0] r2, input logic [XLEN-1:0] d2,
                       input logic sa, input logic sb, input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] imm, input logic [AW-1:0] rd);
    in_valid = 1; in_aluop = op; in_rs1_addr = r1; in_rs1_data = d1;
    in_rs2_addr = r2; in_rs2_data = d2; in_sel_a = sa; in_sel_b = sb;
    in_pc = pc; in_imm = imm; in_rd_addr = rd;
  endtask

  initial begin
    logic [XLEN-1:0] held_a;
    m.valid = 0;
    idle();
    rst = 1;
    #2;
    check("reset out_valid", out_valid, 0);
    check("reset alumux1", alumux1_out, 0);
    check("reset alumux2", alumux2_out, 0);
    check("reset aluop", aluop, 0);
    check("reset rd", out_rd_addr, 0);
    @(negedge clk);
    rst = 0;

    // Basic register operands.
    issue(4'd0, 5'd5, 32'h10, 5'd6, 32'h20, 0, 0, 32'h0, 32'h0, 5'd1);
    step();
    check("t1 valid", out_valid, 1);
    check("t1 a", alumux1_out, 32'h10);
    check("t1 b", alumux2_out, 32'h20);
    check("t1 op", aluop, 0);

    // PC and immediate operands, back-to-back with the previous instruction.
    issue(4'd3, 5'd5, 32'h10, 5'd6, 32'h20, 1, 1, 32'h100, 32'hFFFF_FFFC, 5'd2);
    step();
    check("t2 a", alumux1_out, 32'h100);
    check("t2 b", alumux2_out, 32'hFFFF_FFFC);
    check("t2 op", aluop, 3);

    // Capture-time forwarding, and x0 is never forwarded.
    issue(4'd1, 5'd3, 32'h1, 5'd0, 32'h0, 0, 1, 32'h0, 32'h8, 5'd4);
    wb_valid = 1; wb_rd = 3; wb_data = 32'hABCD;
    step();
    check("t3 fwd a", alumux1_out, FWD ? 32'hABCD : 32'h1);
    issue(4'd1, 5'd0, 32'h77, 5'd0, 32'h0, 0, 1, 32'h0, 32'h8, 5'd4);
    wb_rd = 0;
    step();
    check("t3 x0 a", alumux1_out, 32'h77);
    wb_valid = 0;

    // Hold for 3 cycles with a writeback to held rs2 in the second cycle.
    issue(4'd2, 5'd9, 32'h99, 5'd7, 32'h1234, 0, 0, 32'h0, 32'h0, 5'd8);
    step();
    out_ready = 0;
    issue(4'd5, 5'd1, 32'h1, 5'd2, 32'h2, 0, 0, 32'h0, 32'h0, 5'd3);
    step();
    check("t4 hold b c1", alumux2_out, 32'h1234);
    held_a = alumux1_out;
    wb_valid = 1; wb_rd = 7; wb_data = 32'h55;
    step();
    wb_valid = 0;
    step();
    check("t4 hold b c3", alumux2_out, FWD ? 32'h55 : 32'h1234);
    check("t4 hold a", alumux1_out, 32'h99);
    check("t4 hold a stable", alumux1_out, held_a);
    check("t4 hold op", aluop, 2);
    #1 check("t4 in_ready", in_ready, 0);

    // Flush with a held entry and a new incoming instruction.
    flush = 1;
    step();
    check("t5 flush valid", out_valid, 0);
    #1 check("t5 in_ready", in_ready, 1);
    flush = 0;

    // Asynchronous reset in the middle of a hold.
    issue(4'd6, 5'd4, 32'h44, 5'd5, 32'h55, 0, 0, 32'h0, 32'h0, 5'd6);
    step();
    in_valid = 0;
    step();
    #2 rst = 1;
    #1;
    check("t6 rst valid", out_valid, 0);
    check("t6 rst a", alumux1_out, 0);
    check("t6 rst b", alumux2_out, 0);
    check("t6 rst op", aluop, 0);
    m.valid = 0;
    @(negedge clk);
    rst = 0;
    idle();

    // Randomized traffic with a small register space so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_aluop    = OPW'($urandom);
      in_rs1_addr = AW'($urandom_range(0, 7));
      in_rs2_addr = AW'($urandom_range(0, 7));
      in_rd_addr  = AW'($urandom);
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      in_pc       = $urandom;
      in_imm      = $urandom;
      in_sel_a    = ($urandom_range(0, 3) == 0);
      in_sel_b    = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 15) == 0);
      wb_valid    = ($urandom_range(0, 1) == 1);
      wb_rd       = AW'($urandom_range(0, 7));
      wb_data     = $urandom;
      out_ready   = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
